sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO for buffering between blocks that share one clock domain (pixel/command pipelines, SD/flash data paths). It uses the same trigger/ok handshake as the dual-clock FIFO. It adds:
- arbitrary width and power-of-2 depth
- an occupancy count
- programmable almost-full/almost-empty flags
- a synchronous flush
- sticky overflow/underflow error flags

Output is first-word-fall-through: the head word is presented on `rdata` whenever `rok` is high.

## Interface
Parameters:
- `Width`, 16, data word width in bits (>=1)
- `Size`, 8, depth in words; power of 2, >=2
- `AlmostFull`, Size-2, `almostFull` asserts when level >= this (1..Size)
- `AlmostEmpty`, 2, `almostEmpty` asserts when level <= this (0..Size-1)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst_`  in  1  reset, synchronous, active-low
- `wtrigger`  in  1  write request; accepted when `wok`=1
- `wdata`  in  Width  write data
- `wok`  out  1  space available (not full)
- `rtrigger`  in  1  read/pop request; accepted when `rok`=1
- `rdata`  out  Width  head word (FWFT); valid only while `rok`=1
- `rok`  out  1  data available (not empty)
- `flush`  in  1  synchronous discard of all contents
- `level`  out  $clog2(Size)+1  words currently stored (0..Size)
- `almostFull`  out  1  level >= AlmostFull
- `almostEmpty`  out  1  level <= AlmostEmpty
- `overflow`  out  1  sticky: write attempted while full
- `underflow`  out  1  sticky: read attempted while empty

## Operation
- Storage is `Size` x `Width` memory with no reset or initial value, so RAM inference is preserved.
- Read pointer `rptr` and write pointer `wptr` are each $clog2(Size)+1 bits. The low bits address memory; the MSB is the wrap bit.
  - level = wptr - rptr, modulo 2^(bits).
  - full: level == Size. empty: level == 0.
- Write accept `wa` = wtrigger & wok. On `wa`: mem[wptr] <= wdata; wptr <= wptr+1.
- Read accept `ra` = rtrigger & rok. On `ra`: rptr <= rptr+1.
- `rdata` = mem[rptr low bits], asynchronous read of the current head.
- `rok`, `wok`, `level`, `almostFull` and `almostEmpty` are decoded from the registered pointers only, never from this cycle's triggers.
  - Consequence: when full, a write is rejected even if a read is accepted in the same cycle.
  - Consequence: when empty, a read is rejected even if a write is accepted in the same cycle.
- Simultaneous `wa` and `ra` (0 < level < Size): both pointers advance and `level` is unchanged.
- Pointer wrap: the low bits roll over from Size-1 to 0 and the MSB toggles. Full/empty must stay correct across any number of wraps.
- `overflow` is set on wtrigger & !wok. `underflow` is set on rtrigger & !rok. Both hold until reset or flush. Rejected requests change no other state.
- Priority, highest first: `rst_`=0, then `flush`=1, then normal operation.
  - Reset and flush are identical in effect: rptr = wptr = 0, and `overflow` = `underflow` = 0.
  - Triggers in the same cycle as reset or flush are ignored and do not set the error flags.
  - Memory contents are untouched.
- Reset values: rok=0, wok=1, level=0, almostEmpty=1, almostFull=0, overflow=0, underflow=0. `rdata` is don't-care.

## Timing
- Write-to-read latency is 1 cycle. A write accepted at edge k makes `rok`=1 and `rdata`=that word valid after edge k.
- Read: the pop takes effect at edge k, and the next word (or `rok`=0) is visible after edge k. A reader may pop every cycle.
- A writer may push every cycle while `wok`=1. Sustained throughput is 1 word/cycle in each direction simultaneously.
- `level` and the almost flags update after the same edge as the pointers. The flags are combinational from the `level` register and add no extra latency.
- An error flag becomes visible the cycle after the offending request.
- Reset or flush asserted at edge k: the reset values listed above hold after edge k. A write on the cycle after release is accepted.

## Test plan
- Fill/drain, Width=16, Size=8:
  - Stimulus: write 0x0001..0x0008 on consecutive cycles.
  - Required: wok=0 and level=8 after the 8th write. Then pop 8 times; rdata reads 0x0001..0x0008 in order, and rok=0, level=0 after the last pop.
- Full/empty edges:
  - At level=8, assert wtrigger & rtrigger together. Required: only the read is accepted, level=7, overflow=1.
  - At level=0, assert both together. Required: only the write is accepted, level=1, underflow=1.
- Wrap stress:
  - Stimulus: 1000 cycles of random wtrigger/rtrigger against a reference queue model.
  - Required: rdata and level match the model every cycle, and pointers wrap at least 100 times.
- Thresholds, AlmostFull=6, AlmostEmpty=2:
  - Increment level 0->8. Required: almostEmpty deasserts at level 3; almostFull asserts at level 6.
  - Decrement level 8->0. Required: almostFull deasserts at level 5; almostEmpty asserts at level 2.
- Flush mid-stream:
  - Stimulus: at level=5 with overflow=1, assert flush together with wtrigger=1.
  - Required: next cycle level=0, rok=0, wok=1, overflow=0, and the write is discarded.
- Reset mid-operation:
  - Stimulus: rst_=0 for 1 cycle at level=3.
  - Required: all outputs take their reset values. A write of 0xBEEF on the cycle after release appears on rdata the cycle after that.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FWFT FIFO with level, almost flags, flush, errors
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int Width       = 16,
  parameter int Size        = 8,
  parameter int AlmostFull  = Size - 2,
  parameter int AlmostEmpty = 2
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    wtrigger,
  input  logic [Width-1:0]        wdata,
  output logic                    wok,
  input  logic                    rtrigger,
  output logic [Width-1:0]        rdata,
  output logic                    rok,
  input  logic                    flush,
  output logic [$clog2(Size):0]   level,
  output logic                    almostFull,
  output logic                    almostEmpty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(Size);
  localparam int PW = AW + 1;

  logic [Width-1:0] mem_q [Size];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [PW-1:0] w_level;
  logic          w_wa;
  logic          w_ra;
  logic          w_mem_we;

  // Status is decoded only from registered pointers, so a same-cycle pop
  // never frees space for a push (and vice versa).
  always_comb begin
    w_level     = wptr_q - rptr_q;
    wok         = (w_level != PW'(Size));
    rok         = (w_level != '0);
    w_wa        = wtrigger & wok;
    w_ra        = rtrigger & rok;
    w_mem_we    = 1'b0;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!rst_ || flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      w_mem_we = w_wa;
      if (w_wa)             wptr_d = wptr_q + PW'(1);
      if (w_ra)             rptr_d = rptr_q + PW'(1);
      if (wtrigger && !wok) overflow_d = 1'b1;
      if (rtrigger && !rok) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wptr_q      <= wptr_d;
    rptr_q      <= rptr_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata       = mem_q[rptr_q[AW-1:0]];
  assign level       = w_level;
  assign almostFull  = (w_level >= PW'(AlmostFull));
  assign almostEmpty = (w_level <= PW'(AlmostEmpty));
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo : directed + random checks of sync_fifo against a queue model
// Revision     : 1.0
// ============================================================================
module tb_sync_fifo;

  localparam int WIDTH = 16;
  localparam int SIZE  = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst_;
  logic             wtrigger;
  logic [WIDTH-1:0] wdata;
  logic             wok;
  logic             rtrigger;
  logic [WIDTH-1:0] rdata;
  logic             rok;
  logic             flush;
  logic [3:0]       level;
  logic             almostFull;
  logic             almostEmpty;
  logic             overflow;
  logic             underflow;

  sync_fifo #(
    .Width(WIDTH), .Size(SIZE), .AlmostFull(AF), .AlmostEmpty(AE)
  ) dut (
    .clk(clk), .rst_(rst_), .wtrigger(wtrigger), .wdata(wdata), .wok(wok),
    .rtrigger(rtrigger), .rdata(rdata), .rok(rok), .flush(flush),
    .level(level), .almostFull(almostFull), .almostEmpty(almostEmpty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes_accepted = 0;

  logic [WIDTH-1:0] model_q [$];
  bit               model_ovf;
  bit               model_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = model_q.size();
    chk("level",       {28'd0, level},       n);
    chk("rok",         {31'd0, rok},         (n != 0) ? 1 : 0);
    chk("wok",         {31'd0, wok},         (n != SIZE) ? 1 : 0);
    chk("almostFull",  {31'd0, almostFull},  (n >= AF) ? 1 : 0);
    chk("almostEmpty", {31'd0, almostEmpty}, (n <= AE) ? 1 : 0);
    chk("overflow",    {31'd0, overflow},    {31'd0, model_ovf});
    chk("underflow",   {31'd0, underflow},   {31'd0, model_udf});
    if (n != 0) chk("rdata", {16'd0, rdata}, {16'd0, model_q[0]});
  endtask

  // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
  task automatic step(input bit wt, input logic [WIDTH-1:0] wd, input bit rt,
                      input bit fl, input bit rs_n);
    bit was_full, was_empty;
    rst_     = rs_n;
    flush    = fl;
    wtrigger = wt;
    wdata    = wd;
    rtrigger = rt;
    @(posedge clk);
    was_full  = (model_q.size() == SIZE);
    was_empty = (model_q.size() == 0);
    if (!rs_n || fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
    end else begin
      if (rt && !was_empty) void'(model_q.pop_front());
      if (rt && was_empty)  model_udf = 1'b1;
      if (wt && !was_full) begin
        model_q.push_back(wd);
        writes_accepted++;
      end
      if (wt && was_full)   model_ovf = 1'b1;
    end
    #1;
    check_model();
  endtask

  initial begin
    rst_ = 1'b0; flush = 1'b0; wtrigger = 1'b0; rtrigger = 1'b0; wdata = '0;
    model_ovf = 1'b0; model_udf = 1'b0;

    // Reset
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    chk("reset_rok", {31'd0, rok}, 0);
    chk("reset_wok", {31'd0, wok}, 1);
    chk("reset_ae",  {31'd0, almostEmpty}, 1);

    // Fill / drain with thresholds on the way
    for (int i = 1; i <= 8; i++) begin
      step(1, WIDTH'(i), 0, 0, 1);
      if (i == 2) chk("ae_at2_up", {31'd0, almostEmpty}, 1);
      if (i == 3) chk("ae_off_at3", {31'd0, almostEmpty}, 0);
      if (i == 5) chk("af_off_at5_up", {31'd0, almostFull}, 0);
      if (i == 6) chk("af_on_at6", {31'd0, almostFull}, 1);
    end
    chk("full_wok",   {31'd0, wok}, 0);
    chk("full_level", {28'd0, level}, 8);

    // Full edge: read accepted, write rejected
    step(1, 16'hAAAA, 1, 0, 1);
    chk("full_both_level", {28'd0, level}, 7);
    chk("full_both_ovf",   {31'd0, overflow}, 1);

    for (int i = 2; i <= 8; i++) begin
      chk("drain_rdata", {16'd0, rdata}, i);
      step(0, 16'h0, 1, 0, 1);
      if (i == 3) chk("af_off_at5_dn", {31'd0, almostFull}, 0);
      if (i == 6) chk("ae_on_at2_dn", {31'd0, almostEmpty}, 1);
    end
    chk("empty_rok",   {31'd0, rok}, 0);
    chk("empty_level", {28'd0, level}, 0);

    // Empty edge: write accepted, read rejected
    step(1, 16'h1234, 1, 0, 1);
    chk("empty_both_level", {28'd0, level}, 1);
    chk("empty_both_udf",   {31'd0, underflow}, 1);
    chk("empty_both_rdata", {16'd0, rdata}, 16'h1234);

    // Wrap stress
    step(0, 16'h0, 0, 0, 0);
    writes_accepted = 0;
    for (int c = 0; c < 1600; c++) begin
      step(($urandom % 8) != 0, WIDTH'($urandom), ($urandom % 8) != 0, 0, 1);
    end
    if (writes_accepted < 100 * SIZE) $display("note: only %0d writes in stress", writes_accepted);

    // Flush mid-stream at level 5 with overflow set
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, WIDTH'(16'h100 + i), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, 1);
    chk("pre_flush_level", {28'd0, level}, 5);
    chk("pre_flush_ovf",   {31'd0, overflow}, 1);
    step(1, 16'h5555, 0, 1, 1);
    chk("flush_level", {28'd0, level}, 0);
    chk("flush_rok",   {31'd0, rok}, 0);
    chk("flush_wok",   {31'd0, wok}, 1);
    chk("flush_ovf",   {31'd0, overflow}, 0);
    step(0, 16'h0, 0, 0, 1);
    chk("flush_discard", {31'd0, rok}, 0);

    // Reset mid-operation at level 3
    for (int i = 0; i < 3; i++) step(1, WIDTH'(16'h200 + i), 0, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    chk("pre_rst_udf", {31'd0, underflow}, 1);
    for (int i = 0; i < 3; i++) step(1, WIDTH'(16'h300 + i), 0, 0, 1);
    step(1, 16'h7777, 1, 0, 0);
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_rok",   {31'd0, rok}, 0);
    chk("rst_wok",   {31'd0, wok}, 1);
    chk("rst_af",    {31'd0, almostFull}, 0);
    chk("rst_ae",    {31'd0, almostEmpty}, 1);
    chk("rst_udf",   {31'd0, underflow}, 0);
    step(1, 16'hBEEF, 0, 0, 1);
    chk("post_rst_rok",   {31'd0, rok}, 1);
    chk("post_rst_rdata", {16'd0, rdata}, 16'hBEEF);
    step(0, 16'h0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
